// File: rtl/evg_event_arbiter.sv
// EVG event arbiter: several event sources share the transmitter's single event-code slot.
// Requester 0 has fixed top priority. Requesters 1..NUM_REQ-1 are served round-robin.
// Each requester has a one-entry holding register. Overflowing requests are dropped and counted.
module evg_event_arbiter #(
  parameter int unsigned EVENTCODE_WIDTH    = 8,
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned DROP_COUNTER_WIDTH = 8,
  localparam int unsigned IDX_WIDTH         = $clog2(NUM_REQ)
) (
  input  logic                                    evgTxClk,
  input  logic                                    evgTxRst_n,
  input  logic [NUM_REQ*EVENTCODE_WIDTH-1:0]      reqTDATA,
  input  logic [NUM_REQ-1:0]                      reqTVALID,
  input  logic [NUM_REQ-1:0]                      reqEnable,
  input  logic                                    clearStats,
  output logic [EVENTCODE_WIDTH-1:0]              evgEventTDATA,
  output logic                                    evgEventTVALID,
  input  logic                                    evgEventTREADY,
  output logic [NUM_REQ-1:0]                      pending,
  output logic [NUM_REQ*DROP_COUNTER_WIDTH-1:0]   dropCount,
  output logic [IDX_WIDTH-1:0]                    lastGrant
);

  logic [EVENTCODE_WIDTH-1:0]    holdQ [NUM_REQ];
  logic [EVENTCODE_WIDTH-1:0]    holdD [NUM_REQ];
  logic [DROP_COUNTER_WIDTH-1:0] dropQ [NUM_REQ];
  logic [DROP_COUNTER_WIDTH-1:0] dropD [NUM_REQ];
  logic [NUM_REQ-1:0]            pendingQ, pendingD;
  logic [IDX_WIDTH-1:0]          rrPtrQ, rrPtrD;
  logic [IDX_WIDTH-1:0]          lastGrantQ, lastGrantD;
  logic [EVENTCODE_WIDTH-1:0]    tdataQ, tdataD;
  logic                          tvalidQ, tvalidD;

  logic                          grantValid;
  logic [IDX_WIDTH-1:0]          grantIdx;
  logic [IDX_WIDTH-1:0]          searchIdx;
  logic                          loadOut;
  logic [NUM_REQ-1:0]            grantVec;

  // Grant selection: requester 0 first, then round-robin search from the pointer.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    searchIdx  = '0;
    if (pendingQ[0]) begin
      grantValid = 1'b1;
    end else begin
      // Walk the search order backwards so the entry closest to the pointer wins.
      for (int j = NUM_REQ - 2; j >= 0; j--) begin
        searchIdx = IDX_WIDTH'(((int'(rrPtrQ) - 1 + j) % (int'(NUM_REQ) - 1)) + 1);
        if (pendingQ[searchIdx]) begin
          grantValid = 1'b1;
          grantIdx   = searchIdx;
        end
      end
    end
    loadOut  = (!tvalidQ || evgEventTREADY) && grantValid;
    grantVec = loadOut ? (NUM_REQ'(1) << grantIdx) : '0;
  end

  // Per-requester capture into the holding register, with drop counting.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [EVENTCODE_WIDTH-1:0] code;
      logic                       qual;
      logic                       drop;
      code        = reqTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH];
      qual        = reqTVALID[i] && reqEnable[i] && (code != '0);
      drop        = 1'b0;
      holdD[i]    = holdQ[i];
      pendingD[i] = pendingQ[i];
      dropD[i]    = dropQ[i];
      if (!reqEnable[i]) begin
        pendingD[i] = 1'b0;
      end else if (qual) begin
        // A slot being granted this cycle counts as free.
        if (!pendingQ[i] || grantVec[i]) begin
          holdD[i]    = code;
          pendingD[i] = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (grantVec[i]) begin
        pendingD[i] = 1'b0;
      end
      if (clearStats) begin
        dropD[i] = '0;
      end else if (drop && (dropQ[i] != '1)) begin
        dropD[i] = dropQ[i] + DROP_COUNTER_WIDTH'(1);
      end
    end
  end

  // Output register, last-grant and round-robin pointer update.
  always_comb begin
    tdataD     = tdataQ;
    tvalidD    = tvalidQ;
    lastGrantD = lastGrantQ;
    rrPtrD     = rrPtrQ;
    if (loadOut) begin
      tdataD     = holdQ[grantIdx];
      tvalidD    = 1'b1;
      lastGrantD = grantIdx;
      if (grantIdx != '0) begin
        rrPtrD = (grantIdx == IDX_WIDTH'(NUM_REQ - 1)) ? IDX_WIDTH'(1)
                                                      : grantIdx + IDX_WIDTH'(1);
      end
    end else if (evgEventTREADY) begin
      tvalidD = 1'b0;
    end
  end

  // State registers; reset discards any queued or in-flight event at once.
  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        holdQ[i] <= '0;
        dropQ[i] <= '0;
      end
      pendingQ   <= '0;
      rrPtrQ     <= IDX_WIDTH'(1);
      lastGrantQ <= '0;
      tdataQ     <= '0;
      tvalidQ    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        holdQ[i] <= holdD[i];
        dropQ[i] <= dropD[i];
      end
      pendingQ   <= pendingD;
      rrPtrQ     <= rrPtrD;
      lastGrantQ <= lastGrantD;
      tdataQ     <= tdataD;
      tvalidQ    <= tvalidD;
    end
  end

  // Pack the drop counters onto the flat output bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      dropCount[i*DROP_COUNTER_WIDTH +: DROP_COUNTER_WIDTH] = dropQ[i];
    end
  end

  assign evgEventTDATA  = tdataQ;
  assign evgEventTVALID = tvalidQ;
  assign pending        = pendingQ;
  assign lastGrant      = lastGrantQ;

endmodule
